ex_mem_fwd_latch: RTL and testbench
===================================

Name: ex_mem_fwd_latch

Overview:
- EX/MEM pipeline register for the MIPS datapath.
- Captures ALU result, store data, destination register and MEM/WB control at the end of EX.
- Drives the forwarding selects and forwarding data back into the EX-stage operand muxes (regA / regB-vs-immediate paths).
- Flags a load-use hazard when EX needs a value that is still being loaded.

Parameters:
- DATA_WIDTH, 32, width of datapath words.
- REG_ADDR_WIDTH, 5, width of register-file addresses.

Ports:
- i_clock  input  1  system clock, rising edge.
- i_reset  input  1  asynchronous, active-low reset.
- i_stall  input  1  hold all latched state.
- i_flush  input  1  load a bubble instead of EX contents.
- i_ex_alu_result  input  DATA_WIDTH  ALU output from EX.
- i_ex_store_data  input  DATA_WIDTH  forwarded regB value (store data).
- i_ex_rd  input  REG_ADDR_WIDTH  EX destination register.
- i_ex_rs  input  REG_ADDR_WIDTH  EX source A register.
- i_ex_rt  input  REG_ADDR_WIDTH  EX source B register.
- i_ex_regwrite  input  1  EX instruction writes the register file.
- i_ex_memread  input  1  EX instruction is a load.
- i_ex_memwrite  input  1  EX instruction is a store.
- i_ex_memtoreg  input  1  write-back takes memory data.
- i_wb_regwrite  input  1  MEM/WB instruction writes the register file.
- i_wb_rd  input  REG_ADDR_WIDTH  MEM/WB destination register.
- i_wb_data  input  DATA_WIDTH  MEM/WB write-back value.
- o_mem_alu_result  output  DATA_WIDTH  latched ALU result (memory address / WB data).
- o_mem_store_data  output  DATA_WIDTH  latched store data.
- o_mem_rd  output  REG_ADDR_WIDTH  latched destination register.
- o_mem_regwrite  output  1  latched control.
- o_mem_memread  output  1  latched control.
- o_mem_memwrite  output  1  latched control.
- o_mem_memtoreg  output  1  latched control.
- o_mem_valid  output  1  latched slot holds a real instruction.
- o_fwd_a_sel  output  2  operand A source: 00 regfile, 01 EX/MEM, 10 MEM/WB.
- o_fwd_b_sel  output  2  operand B source, same encoding.
- o_fwd_mem_data  output  DATA_WIDTH  EX/MEM forwarding value (= o_mem_alu_result).
- o_load_use_hazard  output  1  EX source depends on an in-flight load.

Behaviour:
- Reset (i_reset=0, asynchronous): all o_mem_* outputs and o_mem_valid = 0. Consequently o_fwd_*_sel = 00 and o_load_use_hazard = 0.
- Capture on rising edge, priority order:
  1. !i_reset
  2. i_flush: bubble, i.e. valid=0 and all controls=0. Data/rd registers are don't-care but cleared to 0.
  3. i_stall: hold all registers.
  4. Otherwise: load all EX inputs; valid=1.
- Flush wins over stall when both are asserted.
- Latency: exactly 1 cycle from EX inputs to o_mem_*.
- Bubble gating: a bubble never forwards and never raises a hazard. The match term requires o_mem_valid & o_mem_regwrite.
- Forwarding select: combinational from current EX rs/rt and the latched/WB state. Computed for src = i_ex_rs (A) and src = i_ex_rt (B):
  - memhit = o_mem_valid & o_mem_regwrite & !o_mem_memread & (o_mem_rd == src) & (src != 0)
  - wbhit = i_wb_regwrite & (i_wb_rd == src) & (src != 0)
  - sel = memhit ? 01 : wbhit ? 10 : 00. EX/MEM has priority over MEM/WB, because it is the younger producer.
- Register 0 is never forwarded, even if a producer targets it.
- Load-use: o_load_use_hazard = o_mem_valid & o_mem_memread & o_mem_regwrite & (o_mem_rd != 0) & (o_mem_rd == i_ex_rs | o_mem_rd == i_ex_rt).
  - While it is asserted, that source's sel falls back to the MEM/WB or regfile rule.
  - The upstream hazard unit is responsible for stalling or flushing.
- o_fwd_mem_data is wired directly to o_mem_alu_result; no extra cycle.
- Reset mid-stall or mid-flush: reset dominates immediately, with no dependency on the clock.

Test Plan:
- Reset then release; drive EX alu=0x0000_1234, rd=5, regwrite=1, one clock -> o_mem_alu_result=0x1234, o_mem_rd=5, o_mem_valid=1. All outputs were 0 while reset was low.
- Latched rd=5/regwrite=1, EX rs=5, rt=7, WB rd=7/regwrite=1/data=0xAA -> o_fwd_a_sel=01, o_fwd_b_sel=10, o_fwd_mem_data=0x1234.
- Both EX/MEM and MEM/WB target reg 3, EX rs=3 -> o_fwd_a_sel=01 (EX/MEM priority). Same case with rd=0 and rs=0 -> o_fwd_a_sel=00.
- Latched load (memread=1, rd=8), EX rt=8 -> o_load_use_hazard=1 and o_fwd_b_sel=00. Same case with o_mem_valid=0 -> hazard=0.
- i_stall=1 while EX inputs change -> o_mem_* unchanged. i_flush=1 and i_stall=1 together, one clock -> o_mem_valid=0, o_mem_regwrite=0, o_mem_memwrite=0.
- Assert i_reset=0 between clock edges while valid=1 -> all o_mem_* = 0 before the next edge.

Source files
------------

// File: rtl/ex_mem_fwd_latch.sv
// EX/MEM pipeline register for the MIPS datapath, with forwarding-select
// generation for the EX operand muxes and load-use hazard detection.
module ex_mem_fwd_latch #(
  parameter int DATA_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 5
) (
  input  logic                      i_clock,
  input  logic                      i_reset,
  input  logic                      i_stall,
  input  logic                      i_flush,
  input  logic [DATA_WIDTH-1:0]     i_ex_alu_result,
  input  logic [DATA_WIDTH-1:0]     i_ex_store_data,
  input  logic [REG_ADDR_WIDTH-1:0] i_ex_rd,
  input  logic [REG_ADDR_WIDTH-1:0] i_ex_rs,
  input  logic [REG_ADDR_WIDTH-1:0] i_ex_rt,
  input  logic                      i_ex_regwrite,
  input  logic                      i_ex_memread,
  input  logic                      i_ex_memwrite,
  input  logic                      i_ex_memtoreg,
  input  logic                      i_wb_regwrite,
  input  logic [REG_ADDR_WIDTH-1:0] i_wb_rd,
  input  logic [DATA_WIDTH-1:0]     i_wb_data,
  output logic [DATA_WIDTH-1:0]     o_mem_alu_result,
  output logic [DATA_WIDTH-1:0]     o_mem_store_data,
  output logic [REG_ADDR_WIDTH-1:0] o_mem_rd,
  output logic                      o_mem_regwrite,
  output logic                      o_mem_memread,
  output logic                      o_mem_memwrite,
  output logic                      o_mem_memtoreg,
  output logic                      o_mem_valid,
  output logic [1:0]                o_fwd_a_sel,
  output logic [1:0]                o_fwd_b_sel,
  output logic [DATA_WIDTH-1:0]     o_fwd_mem_data,
  output logic                      o_load_use_hazard
);

  localparam logic [REG_ADDR_WIDTH-1:0] REG_ZERO = {REG_ADDR_WIDTH{1'b0}};
  localparam logic [DATA_WIDTH-1:0]     DATA_ZERO = {DATA_WIDTH{1'b0}};

  logic [DATA_WIDTH-1:0]     alu_result_r;
  logic [DATA_WIDTH-1:0]     store_data_r;
  logic [REG_ADDR_WIDTH-1:0] rd_r;
  logic                      regwrite_r;
  logic                      memread_r;
  logic                      memwrite_r;
  logic                      memtoreg_r;
  logic                      valid_r;

  logic                      mem_fwd_ok_s;
  logic                      mem_load_s;
  logic [1:0]                fwd_a_sel_s;
  logic [1:0]                fwd_b_sel_s;
  logic                      load_use_s;
  logic                      wb_data_unused_s;

  // Pipeline capture: flush inserts a bubble and overrides stall.
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      alu_result_r <= DATA_ZERO;
      store_data_r <= DATA_ZERO;
      rd_r         <= REG_ZERO;
      regwrite_r   <= 1'b0;
      memread_r    <= 1'b0;
      memwrite_r   <= 1'b0;
      memtoreg_r   <= 1'b0;
      valid_r      <= 1'b0;
    end else if (i_flush) begin
      alu_result_r <= DATA_ZERO;
      store_data_r <= DATA_ZERO;
      rd_r         <= REG_ZERO;
      regwrite_r   <= 1'b0;
      memread_r    <= 1'b0;
      memwrite_r   <= 1'b0;
      memtoreg_r   <= 1'b0;
      valid_r      <= 1'b0;
    end else if (i_stall) begin
      alu_result_r <= alu_result_r;
      store_data_r <= store_data_r;
      rd_r         <= rd_r;
      regwrite_r   <= regwrite_r;
      memread_r    <= memread_r;
      memwrite_r   <= memwrite_r;
      memtoreg_r   <= memtoreg_r;
      valid_r      <= valid_r;
    end else begin
      alu_result_r <= i_ex_alu_result;
      store_data_r <= i_ex_store_data;
      rd_r         <= i_ex_rd;
      regwrite_r   <= i_ex_regwrite;
      memread_r    <= i_ex_memread;
      memwrite_r   <= i_ex_memwrite;
      memtoreg_r   <= i_ex_memtoreg;
      valid_r      <= 1'b1;
    end
  end

  // EX/MEM beats MEM/WB as the younger producer; register 0 never forwards.
  function automatic logic [1:0] fwd_sel(
    input logic [REG_ADDR_WIDTH-1:0] src,
    input logic                      mem_ok,
    input logic [REG_ADDR_WIDTH-1:0] mem_rd,
    input logic                      wb_we,
    input logic [REG_ADDR_WIDTH-1:0] wb_rd
  );
    logic [1:0] sel;
    if (src == REG_ZERO) begin
      sel = 2'b00;
    end else if (mem_ok && (mem_rd == src)) begin
      sel = 2'b01;
    end else if (wb_we && (wb_rd == src)) begin
      sel = 2'b10;
    end else begin
      sel = 2'b00;
    end
    return sel;
  endfunction

  // Forwarding selects and load-use detection from latched and WB state.
  always_comb begin
    mem_fwd_ok_s = valid_r & regwrite_r & ~memread_r;
    mem_load_s   = valid_r & regwrite_r & memread_r & (rd_r != REG_ZERO);
    fwd_a_sel_s  = fwd_sel(i_ex_rs, mem_fwd_ok_s, rd_r, i_wb_regwrite, i_wb_rd);
    fwd_b_sel_s  = fwd_sel(i_ex_rt, mem_fwd_ok_s, rd_r, i_wb_regwrite, i_wb_rd);
    if (mem_load_s && ((rd_r == i_ex_rs) || (rd_r == i_ex_rt))) begin
      load_use_s = 1'b1;
    end else begin
      load_use_s = 1'b0;
    end
  end

  // The WB value is muxed in EX itself; only its address/enable matter here.
  assign wb_data_unused_s  = ^i_wb_data;

  assign o_mem_alu_result  = alu_result_r;
  assign o_mem_store_data  = store_data_r;
  assign o_mem_rd          = rd_r;
  assign o_mem_regwrite    = regwrite_r;
  assign o_mem_memread     = memread_r;
  assign o_mem_memwrite    = memwrite_r;
  assign o_mem_memtoreg    = memtoreg_r;
  assign o_mem_valid       = valid_r;
  assign o_fwd_mem_data    = alu_result_r;
  assign o_fwd_a_sel       = fwd_a_sel_s;
  assign o_fwd_b_sel       = fwd_b_sel_s;
  assign o_load_use_hazard = load_use_s;

endmodule

// File: tb/tb_ex_mem_fwd_latch.sv
// Directed bench for ex_mem_fwd_latch: the driver queues hand-computed
// expectations, a negedge monitor pops and compares them against the DUT.
module tb_ex_mem_fwd_latch;

  logic        i_clock;
  logic        i_reset;
  logic        i_stall;
  logic        i_flush;
  logic [31:0] i_ex_alu_result;
  logic [31:0] i_ex_store_data;
  logic [4:0]  i_ex_rd;
  logic [4:0]  i_ex_rs;
  logic [4:0]  i_ex_rt;
  logic        i_ex_regwrite;
  logic        i_ex_memread;
  logic        i_ex_memwrite;
  logic        i_ex_memtoreg;
  logic        i_wb_regwrite;
  logic [4:0]  i_wb_rd;
  logic [31:0] i_wb_data;
  logic [31:0] o_mem_alu_result;
  logic [31:0] o_mem_store_data;
  logic [4:0]  o_mem_rd;
  logic        o_mem_regwrite;
  logic        o_mem_memread;
  logic        o_mem_memwrite;
  logic        o_mem_memtoreg;
  logic        o_mem_valid;
  logic [1:0]  o_fwd_a_sel;
  logic [1:0]  o_fwd_b_sel;
  logic [31:0] o_fwd_mem_data;
  logic        o_load_use_hazard;

  typedef struct {
    int          step;
    logic        v, rw, mr, mw, m2r;
    logic [4:0]  rd;
    logic [31:0] alu, st;
    logic [1:0]  fa, fb;
    logic        hz;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   step_no = 0;

  ex_mem_fwd_latch #(.DATA_WIDTH(32), .REG_ADDR_WIDTH(5)) dut (
    .i_clock(i_clock), .i_reset(i_reset), .i_stall(i_stall), .i_flush(i_flush),
    .i_ex_alu_result(i_ex_alu_result), .i_ex_store_data(i_ex_store_data),
    .i_ex_rd(i_ex_rd), .i_ex_rs(i_ex_rs), .i_ex_rt(i_ex_rt),
    .i_ex_regwrite(i_ex_regwrite), .i_ex_memread(i_ex_memread),
    .i_ex_memwrite(i_ex_memwrite), .i_ex_memtoreg(i_ex_memtoreg),
    .i_wb_regwrite(i_wb_regwrite), .i_wb_rd(i_wb_rd), .i_wb_data(i_wb_data),
    .o_mem_alu_result(o_mem_alu_result), .o_mem_store_data(o_mem_store_data),
    .o_mem_rd(o_mem_rd), .o_mem_regwrite(o_mem_regwrite),
    .o_mem_memread(o_mem_memread), .o_mem_memwrite(o_mem_memwrite),
    .o_mem_memtoreg(o_mem_memtoreg), .o_mem_valid(o_mem_valid),
    .o_fwd_a_sel(o_fwd_a_sel), .o_fwd_b_sel(o_fwd_b_sel),
    .o_fwd_mem_data(o_fwd_mem_data), .o_load_use_hazard(o_load_use_hazard)
  );

  initial i_clock = 1'b0;
  always #5 i_clock = ~i_clock;

  task automatic chk(input string name, input int step, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s step %0d: got %h expected %h", name, step, act, exp);
    end
  endtask

  // Monitor: compare one queued expectation per falling edge.
  always @(negedge i_clock) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      chk("valid",    e.step, {31'd0, o_mem_valid},    {31'd0, e.v});
      chk("regwrite", e.step, {31'd0, o_mem_regwrite}, {31'd0, e.rw});
      chk("memread",  e.step, {31'd0, o_mem_memread},  {31'd0, e.mr});
      chk("memwrite", e.step, {31'd0, o_mem_memwrite}, {31'd0, e.mw});
      chk("memtoreg", e.step, {31'd0, o_mem_memtoreg}, {31'd0, e.m2r});
      chk("rd",       e.step, {27'd0, o_mem_rd},       {27'd0, e.rd});
      chk("alu",      e.step, o_mem_alu_result,        e.alu);
      chk("store",    e.step, o_mem_store_data,        e.st);
      chk("fwd_data", e.step, o_fwd_mem_data,          e.alu);
      chk("fwd_a",    e.step, {30'd0, o_fwd_a_sel},    {30'd0, e.fa});
      chk("fwd_b",    e.step, {30'd0, o_fwd_b_sel},    {30'd0, e.fb});
      chk("hazard",   e.step, {31'd0, o_load_use_hazard}, {31'd0, e.hz});
    end
  end

  // Queue the expectation for the coming falling edge, then advance one cycle.
  task automatic expect_step(input logic v, rw, mr, mw, m2r, input logic [4:0] rd,
                             input logic [31:0] alu, st, input logic [1:0] fa, fb,
                             input logic hz);
    exp_t e;
    step_no++;
    e.step = step_no; e.v = v; e.rw = rw; e.mr = mr; e.mw = mw; e.m2r = m2r;
    e.rd = rd; e.alu = alu; e.st = st; e.fa = fa; e.fb = fb; e.hz = hz;
    exp_q.push_back(e);
    @(posedge i_clock);
    #1;
  endtask

  task automatic set_ex(input logic [31:0] alu, st, input logic [4:0] rd,
                        input logic rw, mr, mw, m2r);
    i_ex_alu_result = alu; i_ex_store_data = st; i_ex_rd = rd;
    i_ex_regwrite = rw; i_ex_memread = mr; i_ex_memwrite = mw; i_ex_memtoreg = m2r;
  endtask

  task automatic set_src(input logic [4:0] rs, rt, input logic wb_we,
                         input logic [4:0] wb_rd, input logic [31:0] wb_data);
    i_ex_rs = rs; i_ex_rt = rt; i_wb_regwrite = wb_we; i_wb_rd = wb_rd; i_wb_data = wb_data;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation exceeded time budget");
    $fatal(1, "timeout");
  end

  initial begin
    i_reset = 1'b0; i_stall = 1'b0; i_flush = 1'b0;
    set_ex(32'h0000_1234, 32'h0000_0000, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0);
    set_src(5'd5, 5'd0, 1'b0, 5'd0, 32'h0000_0000);
    @(posedge i_clock);
    #1;
    // 1: reset held, EX inputs present but nothing latched
    expect_step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 32'h0, 2'b00, 2'b00, 1'b0);
    // 2: reset released after the edge, still empty
    i_reset = 1'b1;
    expect_step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 32'h0, 2'b00, 2'b00, 1'b0);
    // 3: first capture; stall and change EX; rs=5 hits EX/MEM, rt=7 hits MEM/WB
    i_stall = 1'b1;
    set_ex(32'h0000_DEAD, 32'h0000_BEEF, 5'd9, 1'b0, 1'b1, 1'b1, 1'b1);
    set_src(5'd5, 5'd7, 1'b1, 5'd7, 32'h0000_00AA);
    expect_step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 5'd5, 32'h0000_1234, 32'h0, 2'b01, 2'b10, 1'b0);
    // 4: stalled, state held; rs=3 only WB matches, rt=0 never forwards
    i_stall = 1'b0;
    set_ex(32'h0000_3333, 32'h0000_5555, 5'd3, 1'b1, 1'b0, 1'b1, 1'b0);
    set_src(5'd3, 5'd0, 1'b1, 5'd3, 32'h0000_0011);
    expect_step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 5'd5, 32'h0000_1234, 32'h0, 2'b10, 2'b00, 1'b0);
    // 5: both stages target reg 3 -> EX/MEM priority
    set_ex(32'h0000_00AB, 32'h0000_0000, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    expect_step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 5'd3, 32'h0000_3333, 32'h0000_5555,
                2'b01, 2'b00, 1'b0);
    // 6: both stages target reg 0, rs=0 -> no forwarding
    set_ex(32'h0000_0100, 32'h0000_0000, 5'd8, 1'b1, 1'b1, 1'b0, 1'b1);
    set_src(5'd0, 5'd0, 1'b1, 5'd0, 32'h0000_0022);
    expect_step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0000_00AB, 32'h0, 2'b00, 2'b00, 1'b0);
    // 7: latched load to reg 8, rt=8 -> hazard, no EX/MEM forward; flush+stall next
    i_flush = 1'b1; i_stall = 1'b1;
    set_ex(32'h0000_FFFF, 32'h0000_7777, 5'd8, 1'b1, 1'b1, 1'b1, 1'b1);
    set_src(5'd2, 5'd8, 1'b0, 5'd0, 32'h0000_0000);
    expect_step(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 5'd8, 32'h0000_0100, 32'h0, 2'b00, 2'b00, 1'b1);
    // 8: flush beat stall -> bubble, no hazard
    i_flush = 1'b0; i_stall = 1'b0;
    set_ex(32'h0000_CAFE, 32'h0000_BEEF, 5'd12, 1'b1, 1'b0, 1'b0, 1'b0);
    expect_step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 32'h0, 2'b00, 2'b00, 1'b0);
    // 9: valid capture, rs=12 -> EX/MEM forward
    set_src(5'd12, 5'd12, 1'b1, 5'd12, 32'h0000_0033);
    expect_step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 5'd12, 32'h0000_CAFE, 32'h0000_BEEF,
                2'b01, 2'b01, 1'b0);
    // 10: reset asserted between edges clears everything before the next edge
    set_src(5'd12, 5'd12, 1'b0, 5'd0, 32'h0000_0000);
    i_reset = 1'b0;
    expect_step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 32'h0, 2'b00, 2'b00, 1'b0);
    // 11: still in reset across a clock edge
    expect_step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 32'h0, 2'b00, 2'b00, 1'b0);
    @(posedge i_clock);
    #1;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
